// File: rtl/ysyx_2022040010_div_pkg.sv
// Shared constants and encodings for the EX-stage iterative divider.
package ysyx_2022040010_div_pkg;

    localparam int unsigned DefXlen  = 64;
    localparam int unsigned DivOpBus = 2;
    localparam int unsigned WordLen  = 32;

    // bit1: remainder select, bit0: unsigned
    typedef enum logic [DivOpBus-1:0] {
        OpDiv  = 2'b00,
        OpDivu = 2'b01,
        OpRem  = 2'b10,
        OpRemu = 2'b11
    } div_op_e;

    typedef enum logic [1:0] {
        StIdle = 2'b00,
        StBusy = 2'b01,
        StDone = 2'b10
    } div_state_e;

endpackage

// File: rtl/ysyx_2022040010_div_fix.sv
// Combinational operand conditioning (extension, magnitude, special cases) and
// result fix-up (sign restore, quotient/remainder select, W sign-extension).
module ysyx_2022040010_div_fix
    import ysyx_2022040010_div_pkg::*;
#(
    parameter int unsigned XLEN = DefXlen
) (
    input  logic            i_pre_unsigned,
    input  logic            i_pre_word,
    input  logic [XLEN-1:0] i_src1,
    input  logic [XLEN-1:0] i_src2,
    output logic [XLEN-1:0] o_abs1,
    output logic [XLEN-1:0] o_abs2,
    output logic            o_quo_neg,
    output logic            o_rem_neg,
    output logic            o_special,
    output logic [XLEN-1:0] o_spec_quo,
    output logic [XLEN-1:0] o_spec_rem,

    input  logic            i_post_rem_sel,
    input  logic            i_post_word,
    input  logic            i_post_special,
    input  logic            i_post_quo_neg,
    input  logic            i_post_rem_neg,
    input  logic [XLEN-1:0] i_quo,
    input  logic [XLEN-1:0] i_rem,
    output logic [XLEN-1:0] o_result
);

    logic            w_signed;
    logic [XLEN-1:0] w_ext1;
    logic [XLEN-1:0] w_ext2;
    logic            w_s1;
    logic            w_s2;
    logic [XLEN-1:0] w_min;
    logic            w_div0;
    logic            w_ovf;
    logic [XLEN-1:0] w_quo_fix;
    logic [XLEN-1:0] w_rem_fix;
    logic [XLEN-1:0] w_sel;

    assign w_signed = ~i_pre_unsigned;

    always_comb begin
        w_ext1 = i_src1;
        w_ext2 = i_src2;
        if (i_pre_word) begin
            w_ext1 = {{(XLEN-WordLen){w_signed & i_src1[WordLen-1]}}, i_src1[WordLen-1:0]};
            w_ext2 = {{(XLEN-WordLen){w_signed & i_src2[WordLen-1]}}, i_src2[WordLen-1:0]};
        end
    end

    assign w_s1   = w_signed & w_ext1[XLEN-1];
    assign w_s2   = w_signed & w_ext2[XLEN-1];
    assign o_abs1 = w_s1 ? (~w_ext1 + 1'b1) : w_ext1;
    assign o_abs2 = w_s2 ? (~w_ext2 + 1'b1) : w_ext2;

    assign o_quo_neg = w_s1 ^ w_s2;
    assign o_rem_neg = w_s1;

    // Most negative value after extension, so the W case compares sign-extended operands
    assign w_min = i_pre_word ? {{(XLEN-WordLen+1){1'b1}}, {(WordLen-1){1'b0}}}
                              : {1'b1, {(XLEN-1){1'b0}}};

    assign w_div0    = (w_ext2 == '0);
    assign w_ovf     = w_signed & (w_ext1 == w_min) & (w_ext2 == '1);
    assign o_special = w_div0 | w_ovf;

    always_comb begin
        o_spec_quo = w_ext1;
        o_spec_rem = '0;
        if (w_div0) begin
            o_spec_quo = '1;
            o_spec_rem = w_ext1;
        end
    end

    // Special-case registers already hold final values, so no sign restore for them
    assign w_quo_fix = (i_post_quo_neg & ~i_post_special) ? (~i_quo + 1'b1) : i_quo;
    assign w_rem_fix = (i_post_rem_neg & ~i_post_special) ? (~i_rem + 1'b1) : i_rem;
    assign w_sel     = i_post_rem_sel ? w_rem_fix : w_quo_fix;

    assign o_result = i_post_word ? {{(XLEN-WordLen){w_sel[WordLen-1]}}, w_sel[WordLen-1:0]}
                                  : w_sel;

endmodule

// File: rtl/ysyx_2022040010_div.sv
// Radix-2 restoring divider for RV64M DIV/DIVU/REM/REMU and W forms; holds EX via
// stallreq while iterating and presents the result until the pipeline advances.
module ysyx_2022040010_div
    import ysyx_2022040010_div_pkg::*;
#(
    parameter int unsigned XLEN = DefXlen
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic                i_flush,
    input  logic                i_ex_stall,
    input  logic                i_div_valid,
    input  logic [DivOpBus-1:0] i_div_op,
    input  logic                i_div_word,
    input  logic [XLEN-1:0]     i_src1,
    input  logic [XLEN-1:0]     i_src2,
    output logic [XLEN-1:0]     o_result,
    output logic                o_result_valid,
    output logic                o_stallreq_for_ex
);

    localparam int unsigned CntW = $clog2(XLEN + 1);

    div_state_e      r_state, w_state_nxt;
    logic [CntW-1:0] r_cnt, w_cnt_nxt;
    logic [XLEN-1:0] r_rem, w_rem_nxt;
    logic [XLEN-1:0] r_quo, w_quo_nxt;
    logic [XLEN-1:0] r_dvs, w_dvs_nxt;
    logic            r_quo_neg, w_quo_neg_nxt;
    logic            r_rem_neg, w_rem_neg_nxt;
    logic            r_special, w_special_nxt;
    logic            r_rem_sel, w_rem_sel_nxt;
    logic            r_word, w_word_nxt;

    logic [XLEN-1:0] w_abs1;
    logic [XLEN-1:0] w_abs2;
    logic            w_quo_neg;
    logic            w_rem_neg;
    logic            w_special;
    logic [XLEN-1:0] w_spec_quo;
    logic [XLEN-1:0] w_spec_rem;
    logic [XLEN-1:0] w_fix_result;
    logic [XLEN:0]   w_rem_sh;
    logic [XLEN:0]   w_diff;
    logic            w_done;

    ysyx_2022040010_div_fix #(
        .XLEN (XLEN)
    ) u_fix (
        .i_pre_unsigned (i_div_op[0]),
        .i_pre_word     (i_div_word),
        .i_src1         (i_src1),
        .i_src2         (i_src2),
        .o_abs1         (w_abs1),
        .o_abs2         (w_abs2),
        .o_quo_neg      (w_quo_neg),
        .o_rem_neg      (w_rem_neg),
        .o_special      (w_special),
        .o_spec_quo     (w_spec_quo),
        .o_spec_rem     (w_spec_rem),
        .i_post_rem_sel (r_rem_sel),
        .i_post_word    (r_word),
        .i_post_special (r_special),
        .i_post_quo_neg (r_quo_neg),
        .i_post_rem_neg (r_rem_neg),
        .i_quo          (r_quo),
        .i_rem          (r_rem),
        .o_result       (w_fix_result)
    );

    // Trial subtract is one bit wider than the divisor so it cannot overflow
    assign w_rem_sh = {r_rem, r_quo[XLEN-1]};
    assign w_diff   = w_rem_sh - {1'b0, r_dvs};

    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = r_cnt;
        w_rem_nxt     = r_rem;
        w_quo_nxt     = r_quo;
        w_dvs_nxt     = r_dvs;
        w_quo_neg_nxt = r_quo_neg;
        w_rem_neg_nxt = r_rem_neg;
        w_special_nxt = r_special;
        w_rem_sel_nxt = r_rem_sel;
        w_word_nxt    = r_word;

        unique case (r_state)
            StIdle: begin
                if (i_div_valid && !i_flush) begin
                    w_rem_sel_nxt = i_div_op[1];
                    w_word_nxt    = i_div_word;
                    w_quo_neg_nxt = w_quo_neg;
                    w_rem_neg_nxt = w_rem_neg;
                    w_dvs_nxt     = w_abs2;
                    w_cnt_nxt     = i_div_word ? CntW'(WordLen) : CntW'(XLEN);
                    w_special_nxt = w_special;
                    if (w_special) begin
                        w_quo_nxt   = w_spec_quo;
                        w_rem_nxt   = w_spec_rem;
                        w_state_nxt = StDone;
                    end else begin
                        // W dividend sits in the top half so the shift feeds bit 31 first
                        w_quo_nxt   = i_div_word ? {w_abs1[WordLen-1:0], {(XLEN-WordLen){1'b0}}}
                                                 : w_abs1;
                        w_rem_nxt   = '0;
                        w_state_nxt = StBusy;
                    end
                end
            end
            StBusy: begin
                if (!w_diff[XLEN]) begin
                    w_rem_nxt = w_diff[XLEN-1:0];
                    w_quo_nxt = {r_quo[XLEN-2:0], 1'b1};
                end else begin
                    w_rem_nxt = w_rem_sh[XLEN-1:0];
                    w_quo_nxt = {r_quo[XLEN-2:0], 1'b0};
                end
                w_cnt_nxt = r_cnt - 1'b1;
                if (r_cnt == CntW'(1)) begin
                    w_state_nxt = StDone;
                end
            end
            StDone: begin
                if (!i_ex_stall) begin
                    w_state_nxt = StIdle;
                end
            end
            default: w_state_nxt = StIdle;
        endcase

        if (i_flush) begin
            w_state_nxt = StIdle;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state   <= StIdle;
            r_cnt     <= '0;
            r_rem     <= '0;
            r_quo     <= '0;
            r_dvs     <= '0;
            r_quo_neg <= 1'b0;
            r_rem_neg <= 1'b0;
            r_special <= 1'b0;
            r_rem_sel <= 1'b0;
            r_word    <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_rem     <= w_rem_nxt;
            r_quo     <= w_quo_nxt;
            r_dvs     <= w_dvs_nxt;
            r_quo_neg <= w_quo_neg_nxt;
            r_rem_neg <= w_rem_neg_nxt;
            r_special <= w_special_nxt;
            r_rem_sel <= w_rem_sel_nxt;
            r_word    <= w_word_nxt;
        end
    end

    assign w_done            = (r_state == StDone);
    assign o_stallreq_for_ex = i_div_valid & ~w_done & ~i_flush;
    assign o_result_valid    = w_done & ~i_flush;
    assign o_result          = w_done ? w_fix_result : '0;

endmodule

// File: tb/tb_ysyx_2022040010_div.sv
// Self-checking bench: vector table plus hand sequences for stall-hold, flush and reset.
module tb_ysyx_2022040010_div;
    import ysyx_2022040010_div_pkg::*;

    logic        clk;
    logic        rst;
    logic        flush;
    logic        ex_stall;
    logic        div_valid;
    logic [1:0]  div_op;
    logic        div_word;
    logic [63:0] src1;
    logic [63:0] src2;
    logic [63:0] result;
    logic        result_valid;
    logic        stallreq;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [63:0] res;
        int          stall;
    } exp_t;

    typedef struct {
        logic [1:0]  op;
        logic        word;
        logic [63:0] a;
        logic [63:0] b;
        logic [63:0] res;
        int          stall;
        string       name;
    } vec_t;

    exp_t sb[$];
    vec_t vecs[$];

    ysyx_2022040010_div #(
        .XLEN (64)
    ) dut (
        .i_clk             (clk),
        .i_rst             (rst),
        .i_flush           (flush),
        .i_ex_stall        (ex_stall),
        .i_div_valid       (div_valid),
        .i_div_op          (div_op),
        .i_div_word        (div_word),
        .i_src1            (src1),
        .i_src2            (src2),
        .o_result          (result),
        .o_result_valid    (result_valid),
        .o_stallreq_for_ex (stallreq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic add_vec(input div_op_e op, input logic word, input logic [63:0] a,
                           input logic [63:0] b, input logic [63:0] res, input int stall,
                           input string name);
        vec_t v;
        v.op = op; v.word = word; v.a = a; v.b = b;
        v.res = res; v.stall = stall; v.name = name;
        vecs.push_back(v);
    endtask

    // Issue one op, count stall cycles until result_valid, optionally hold EX stalled.
    task automatic run_op(input logic [1:0] op, input logic word, input logic [63:0] a,
                          input logic [63:0] b, input logic [63:0] res, input int stall,
                          input int hold, input string name);
        exp_t e;
        int   stalls;
        bit   seen;
        @(negedge clk);
        div_valid = 1'b1; div_op = op; div_word = word; src1 = a; src2 = b;
        ex_stall  = 1'b0;
        e.res = res; e.stall = stall;
        sb.push_back(e);
        stalls = 0;
        seen   = 1'b0;
        for (int c = 0; c < 200 && !seen; c++) begin
            #1;
            if (result_valid) begin
                seen = 1'b1;
            end else begin
                if (stallreq) stalls++;
                @(negedge clk);
            end
        end
        if (!seen) begin
            checks++;
            failures++;
            $display("FAIL %s timeout: got no result_valid required one within 200 cycles", name);
            e = sb.pop_front();
        end else begin
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL %s scoreboard: got result with no expected entry", name);
            end else begin
                e = sb.pop_front();
                check({name, " result"}, result, e.res);
                check({name, " stalls"}, 64'(stalls), 64'(e.stall));
                check({name, " stallreq@done"}, {63'b0, stallreq}, 64'd0);
                ex_stall = (hold > 0);
                for (int h = 1; h <= hold; h++) begin
                    @(negedge clk);
                    ex_stall = (h < hold);
                    #1;
                    check({name, " hold valid"}, {63'b0, result_valid}, 64'd1);
                    check({name, " hold result"}, result, e.res);
                    check({name, " hold stallreq"}, {63'b0, stallreq}, 64'd0);
                end
            end
            @(negedge clk);
            div_valid = 1'b0;
            ex_stall  = 1'b0;
            #1;
            check({name, " retire"}, {62'b0, result_valid, stallreq}, 64'd0);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no finish required finish before time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; flush = 1'b0; ex_stall = 1'b0; div_valid = 1'b0;
        div_op = 2'b00; div_word = 1'b0; src1 = '0; src2 = '0;

        add_vec(OpDiv,  1'b0, 64'd100, 64'hFFFF_FFFF_FFFF_FFF9, 64'hFFFF_FFFF_FFFF_FFF2, 65, "div 100/-7");
        add_vec(OpRem,  1'b0, 64'd100, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 65, "rem 100/-7");
        add_vec(OpDivu, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 64'h7FFF_FFFF_FFFF_FFFF, 65, "divu max/2");
        add_vec(OpRemu, 1'b1, 64'h1_0000_0007, 64'd3, 64'd1, 33, "remuw 7/3");
        add_vec(OpDiv,  1'b0, 64'h1234, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1, "div by 0");
        add_vec(OpRem,  1'b0, 64'h1234, 64'd0, 64'h1234, 1, "rem by 0");
        add_vec(OpDiv,  1'b1, 64'h8000_0000, 64'hFFFF_FFFF, 64'hFFFF_FFFF_8000_0000, 1, "divw ovf");
        add_vec(OpDiv,  1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF,
                64'h8000_0000_0000_0000, 1, "div ovf");
        add_vec(OpRem,  1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1, "rem ovf");
        add_vec(OpDivu, 1'b1, 64'hFFFF_FFFF, 64'd1, 64'hFFFF_FFFF_FFFF_FFFF, 33, "divuw sext");
        add_vec(OpRem,  1'b1, 64'hFFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 33, "remw -7/2");
        add_vec(OpDiv,  1'b1, 64'h1_0000_000A, 64'd2, 64'd5, 33, "divw 10/2");
        add_vec(OpRemu, 1'b0, 64'd10, 64'd0, 64'd10, 1, "remu by 0");
        add_vec(OpRemu, 1'b1, 64'hABCD_0000_8000_0005, 64'hFFFF_0000_0000_0000,
                64'hFFFF_FFFF_8000_0005, 1, "remuw by 0");

        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("reset outputs", {result_valid, stallreq, result[61:0]}, 64'd0);
        check("reset result", result, 64'd0);

        foreach (vecs[i]) begin
            run_op(vecs[i].op, vecs[i].word, vecs[i].a, vecs[i].b, vecs[i].res,
                   vecs[i].stall, 0, vecs[i].name);
        end

        run_op(OpDivu, 1'b0, 64'd10, 64'd3, 64'd3, 65, 5, "divu hold");

        // Flush at BUSY cycle 20
        @(negedge clk);
        div_valid = 1'b1; div_op = OpDiv; div_word = 1'b0; src1 = 64'd1000; src2 = 64'd7;
        for (int c = 1; c <= 20; c++) begin
            #1;
            if (c == 1) check("flush pre stallreq", {63'b0, stallreq}, 64'd1);
            @(negedge clk);
        end
        flush = 1'b1;
        #1;
        check("flush stallreq", {63'b0, stallreq}, 64'd0);
        check("flush valid", {63'b0, result_valid}, 64'd0);
        @(negedge clk);
        flush = 1'b0; div_valid = 1'b0;
        #1;
        check("post flush valid 1", {63'b0, result_valid}, 64'd0);
        @(negedge clk);
        #1;
        check("post flush valid 2", {63'b0, result_valid}, 64'd0);
        run_op(OpDiv, 1'b0, 64'd9, 64'd3, 64'd3, 65, 0, "div 9/3 after flush");

        // Reset mid-BUSY
        @(negedge clk);
        div_valid = 1'b1; div_op = OpDiv; div_word = 1'b0; src1 = 64'd77; src2 = 64'd5;
        repeat (10) @(negedge clk);
        rst = 1'b1; div_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("mid reset flags", {62'b0, result_valid, stallreq}, 64'd0);
        check("mid reset result", result, 64'd0);
        run_op(OpDiv, 1'b0, 64'hFFFF_FFFF_FFFF_FFF7, 64'd2, 64'hFFFF_FFFF_FFFF_FFFC, 65, 0,
               "div -9/2");
        run_op(OpRem, 1'b0, 64'hFFFF_FFFF_FFFF_FFF7, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 65, 0,
               "rem -9/2");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
